// File: rtl/vga_pkg.sv
// Shared definitions for the VRAM arbiter: FSM encoding and default geometry.
package vga_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        DISP_RD  = 2'b01,
        DISP_CAP = 2'b10,
        HOST_WR  = 2'b11
    } arb_state_e;

    localparam int COLS_DEF   = 64;
    localparam int ROWS_DEF   = 48;
    localparam int DATA_W_DEF = 3;

endpackage

// File: rtl/vram_evt_detect.sv
// Flags a display fetch whenever the active pixel coordinate differs from the
// previous cycle's, or the active region has just been entered.
module vram_evt_detect #(
    parameter int HW = 6,
    parameter int VW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          active,
    input  logic [HW-1:0] hpixel,
    input  logic [VW-1:0] vpixel,
    output logic          disp_evt
);

    logic          prev_active_q;
    logic [HW-1:0] prev_h_q;
    logic [VW-1:0] prev_v_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_active_q <= 1'b0;
            prev_h_q      <= '0;
            prev_v_q      <= '0;
        end else begin
            prev_active_q <= active;
            prev_h_q      <= hpixel;
            prev_v_q      <= vpixel;
        end
    end

    assign disp_evt = active && (!prev_active_q || hpixel != prev_h_q || vpixel != prev_v_q);

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display reads take strict priority, host writes fill
// the gaps. Define VRAM_ARB_BLANK_EN to blank pix_rgb to 0 outside the active region.
module vram_arbiter
    import vga_pkg::*;
#(
    parameter int COLS   = COLS_DEF,
    parameter int ROWS   = ROWS_DEF,
    parameter int ADDR_W = 12,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hdeactivate,
    input  logic              vdeactivate,
    input  logic [5:0]        hpixel,
    input  logic [5:0]        vpixel,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_rgb
);

    localparam int COL_W = $clog2(COLS);
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(ROWS * COLS);

    arb_state_e        state_q, state_d;
    logic              disp_pend_q, disp_pend_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] pix_q, pix_d;

    logic              active, disp_evt, host_in_range;
    logic [ADDR_W-1:0] disp_addr;

    assign active        = !hdeactivate && !vdeactivate;
    assign disp_addr     = ADDR_W'({vpixel, hpixel[COL_W-1:0]});
    assign host_in_range = {1'b0, host_addr} < LIMIT;
    assign host_ready    = reset && (state_q == IDLE) && !disp_evt && !disp_pend_q;

    vram_evt_detect #(.HW(6), .VW(6)) u_evt (
        .clk      (clk),
        .reset    (reset),
        .active   (active),
        .hpixel   (hpixel),
        .vpixel   (vpixel),
        .disp_evt (disp_evt)
    );

    // Strobes are computed from the next state so they line up with the
    // registered state: mem_en is high exactly while in DISP_RD or HOST_WR.
    always_comb begin
        state_d     = state_q;
        disp_pend_d = disp_pend_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        pix_d       = pix_q;
        case (state_q)
            IDLE: begin
                if (disp_evt || disp_pend_q) begin
                    state_d     = DISP_RD;
                    disp_pend_d = 1'b0;
                    mem_en_d    = 1'b1;
                    mem_addr_d  = disp_addr;
                end else if (host_valid && host_ready && host_in_range) begin
                    state_d     = HOST_WR;
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = host_addr;
                    mem_wdata_d = host_data;
                end
            end
            DISP_RD:  state_d = DISP_CAP;
            DISP_CAP: begin
                state_d = IDLE;
                pix_d   = mem_rdata;
            end
            HOST_WR:  state_d = IDLE;
        endcase
        // Events while busy merge into one pending fetch at the latest coordinate.
        if (state_q != IDLE && disp_evt) disp_pend_d = 1'b1;
`ifdef VRAM_ARB_BLANK_EN
        if (!active) pix_d = '0;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            disp_pend_q <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            pix_q       <= '0;
        end else begin
            state_q     <= state_d;
            disp_pend_q <= disp_pend_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            pix_q       <= pix_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign pix_rgb   = pix_q;

endmodule
